// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
    localparam logic [INST_W-1:0] INST_ZERO = '0;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel: req/gnt handshake, rvalid response.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_inst_buf.sv
// Single-entry instruction buffer feeding the decode register; contents hold until reloaded.
module fetch_inst_buf
    import fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              load,
    input  logic              clear,
    input  logic              consume,
    input  logic [INST_W-1:0] load_inst,
    input  logic [XLEN-1:0]   load_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;

    // A refill in the same cycle as a consume keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
            pc4_d   = load_pc + 32'd4;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid_q <= 1'b0;
            inst_q  <= INST_ZERO;
            pc_q    <= '0;
            pc4_q   <= 32'd4;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid    = valid_q;
    assign inst     = inst_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps at most one request outstanding to
// instruction memory and presents one buffered instruction to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              StallF,
    input  logic              Redirect,
    input  logic [XLEN-1:0]   PCTargetE,
    fetch_unit_if.master      imem,
    output logic [INST_W-1:0] InstF,
    output logic [XLEN-1:0]   PCF,
    output logic [XLEN-1:0]   PCPlus4F,
    output logic              BubbleF
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] next_addr;
    logic            buf_valid;
    logic            buf_load;
    logic            consume;
    logic            space;

    assign consume   = buf_valid & ~StallF & ~Redirect;
    assign space     = ~buf_valid | consume;
    assign next_addr = fetch_addr_q + 32'd4;

    always_comb begin
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        buf_load       = 1'b0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = fetch_addr_q;
        if (Redirect) begin
            fetch_addr_d = word_align(PCTargetE);
            if (state_q == WAIT || state_q == DRAIN)
                state_d = imem.imem_rvalid ? REQ : DRAIN;
            else
                state_d = REQ;
        end else begin
            case (state_q)
                REQ: begin
                    imem.imem_req = space & nrst;
                    if (space && nrst && imem.imem_gnt)
                        state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (space) begin
                            buf_load       = 1'b1;
                            imem.imem_req  = 1'b1;
                            imem.imem_addr = next_addr;
                            fetch_addr_d   = next_addr;
                            state_d        = imem.imem_gnt ? WAIT : REQ;
                        end else begin
                            // Decode held a full buffer: drop the word and refetch it later.
                            state_d = REQ;
                        end
                    end
                end
                DRAIN: begin
                    if (imem.imem_rvalid)
                        state_d = REQ;
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= REQ;
            fetch_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    fetch_inst_buf u_buf (
        .clk       (clk),
        .nrst      (nrst),
        .load      (buf_load),
        .clear     (Redirect),
        .consume   (consume),
        .load_inst (imem.imem_rdata),
        .load_pc   (fetch_addr_q),
        .valid     (buf_valid),
        .inst      (InstF),
        .pc        (PCF),
        .pc_plus4  (PCPlus4F)
    );

    assign BubbleF = ~buf_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a behavioural memory and
// an in-order expected-PC model of the delivered instruction stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        nrst, nrst_b;
    logic        stall_f, redirect, b_stall, b_redir;
    logic [31:0] pc_target, b_target;
    logic [31:0] inst_f, pcf, pc4f, b_inst, b_pcf, b_pc4;
    logic        bubble_f, b_bubble;

    fetch_unit_if imem_a ();
    fetch_unit_if imem_b ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .nrst(nrst), .StallF(stall_f), .Redirect(redirect), .PCTargetE(pc_target),
        .imem(imem_a), .InstF(inst_f), .PCF(pcf), .PCPlus4F(pc4f), .BubbleF(bubble_f));

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .nrst(nrst_b), .StallF(b_stall), .Redirect(b_redir), .PCTargetE(b_target),
        .imem(imem_b), .InstF(b_inst), .PCF(b_pcf), .PCPlus4F(b_pc4), .BubbleF(b_bubble));

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    int cyc = 0;
    // stimulus knobs
    logic        stall_in = 0, redir_in = 0;
    logic [31:0] tgt_in = 0;
    int gd_lo = 0, gd_hi = 0, lat_lo = 1, lat_hi = 1;
    // memory model A
    bit          pend = 0;
    logic [31:0] pend_addr = 0;
    int          due = 0, gcnt = 0, gnt_dly = 0;
    // memory model B (zero-wait)
    bit          b_pend = 0;
    logic [31:0] b_paddr = 0;
    // stream model
    logic [31:0] exp_pc = 0, last_pc = 0, last_inst = 0;
    int          deliveries = 0;
    logic        prev_bub = 1, prev_stall = 0, prev_redir = 0;
    // observations of the current cycle
    logic        obs_req, obs_bub, obs_b_req, obs_b_bub;
    logic [31:0] obs_addr, obs_pcf, obs_b_addr, obs_b_pcf, obs_b_pc4, obs_b_inst;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'hC0DE_5A5A) + {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic rv, brv;
        @(negedge clk);
        stall_f = stall_in; redirect = redir_in; pc_target = tgt_in;
        rv = nrst && pend && (due == cyc);
        imem_a.imem_rvalid = rv;
        imem_a.imem_rdata  = rv ? memf(pend_addr) : INST_NOP;
        brv = nrst_b && b_pend;
        imem_b.imem_rvalid = brv;
        imem_b.imem_rdata  = brv ? memf(b_paddr) : INST_NOP;
        imem_b.imem_gnt    = 1'b1;
        #1;
        imem_a.imem_gnt = (gcnt >= gnt_dly);
        #1;
        obs_req = imem_a.imem_req;   obs_addr = imem_a.imem_addr;
        obs_bub = bubble_f;          obs_pcf = pcf;
        obs_b_req = imem_b.imem_req; obs_b_addr = imem_b.imem_addr;
        obs_b_bub = b_bubble;        obs_b_pcf = b_pcf; obs_b_pc4 = b_pc4; obs_b_inst = b_inst;
        if (nrst) begin
            check("one_outstanding", imem_a.imem_req & pend & ~rv, 0);
            if (redirect) check("req_on_redirect", imem_a.imem_req, 0);
            if (!bubble_f && stall_f) check("req_when_full", imem_a.imem_req, 0);
            if (!bubble_f) begin
                check("pcf_stream", pcf, exp_pc);
                check("inst_stream", inst_f, memf(exp_pc));
                check("pcplus4_stream", pc4f, exp_pc + 32'd4);
                last_pc = exp_pc; last_inst = memf(exp_pc);
            end else begin
                check("pcf_hold", pcf, last_pc);
                check("inst_hold", inst_f, last_inst);
                check("pcplus4_hold", pc4f, last_pc + 32'd4);
            end
            if (prev_redir) check("bubble_after_redirect", bubble_f, 1);
            else if (!prev_bub && prev_stall) check("stall_keeps_valid", bubble_f, 0);
            prev_bub = bubble_f; prev_stall = stall_f; prev_redir = redirect;
            if (redirect) exp_pc = {pc_target[31:2], 2'b00};
            else if (!bubble_f && !stall_f) begin exp_pc += 32'd4; deliveries++; end
            if (rv) pend = 0;
            if (imem_a.imem_req && imem_a.imem_gnt) begin
                pend = 1; pend_addr = imem_a.imem_addr;
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                gcnt = 0; gnt_dly = int'($urandom_range(gd_hi, gd_lo));
            end else if (imem_a.imem_req) gcnt++;
        end else begin
            pend = 0; gcnt = 0; exp_pc = 0; last_pc = 0; last_inst = 0;
            prev_bub = 1; prev_stall = 0; prev_redir = 0;
        end
        if (!nrst_b) b_pend = 0;
        else begin b_pend = imem_b.imem_req; b_paddr = imem_b.imem_addr; end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        logic found = 0;
        for (int k = 0; k < 12 && !found; k++) begin step(); found = obs_req; end
        check({tag, "_req_seen"}, found, 1);
        check({tag, "_addr"}, obs_addr, addr);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        logic found = 0;
        for (int k = 0; k < 16 && !found; k++) begin step(); found = !obs_bub; end
        check({tag, "_valid_seen"}, found, 1);
        check({tag, "_pc"}, obs_pcf, pc);
    endtask

    initial begin
        logic [31:0] wrap_addr [3];
        logic        last_b;
        int          d0;
        logic        hit;
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        nrst = 0; nrst_b = 0; stall_f = 0; redirect = 0; pc_target = 0;
        b_stall = 0; b_redir = 0; b_target = 0;
        imem_a.imem_gnt = 0; imem_a.imem_rvalid = 0; imem_a.imem_rdata = 0;
        imem_b.imem_gnt = 0; imem_b.imem_rvalid = 0; imem_b.imem_rdata = 0;

        // reset values
        step(); step();
        check("rst_inst", inst_f, 0);   check("rst_pcf", pcf, 0);
        check("rst_pc4", pc4f, 4);      check("rst_bubble", obs_bub, 1);
        check("rst_req", obs_req, 0);   check("rst_b_pc4", obs_b_pc4, 4);
        check("rst_b_req", obs_b_req, 0);
        nrst = 1;

        // zero-wait streaming from RESET_PC
        for (int i = 0; i < 8; i++) begin
            step();
            check("p1_req", obs_req, 1);
            check("p1_addr", obs_addr, 32'(4 * i));
            if (i < 2) check("p1_bubble_early", obs_bub, 1);
            if (i == 2) begin check("p1_first_valid", obs_bub, 0); check("p1_first_pc", obs_pcf, 0); end
        end

        // decode stall with a full buffer
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("p2_stall_req", obs_req, 0);
            check("p2_stall_pc", obs_pcf, 32'h18);
            check("p2_stall_valid", obs_bub, 0);
        end
        stall_in = 0;
        step();
        check("p2_release_pc", obs_pcf, 32'h18);
        check("p2_refetch_addr", obs_addr, 32'h1C);
        wait_valid("p2_resume", 32'h1C);

        // redirect while waiting without a response -> drain the late word
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 20 && !(pend && due != cyc); k++) step();
        check("p3_reach_wait", pend && due != cyc, 1);
        redir_in = 1; tgt_in = 32'h0000_1002;
        step();
        redir_in = 0;
        step();
        check("p3_drain_req", obs_req, 0);
        wait_req("p3_target", 32'h0000_1000);
        wait_valid("p3_first", 32'h0000_1000);

        // redirect coinciding with rvalid
        lat_lo = 1; lat_hi = 1;
        step(); step(); step();
        for (int k = 0; k < 20 && !(pend && due == cyc); k++) step();
        check("p4_reach_rvalid", pend && due == cyc, 1);
        redir_in = 1; tgt_in = 32'h0000_2001;
        step();
        redir_in = 0;
        step();
        check("p4_req_next", obs_req, 1);
        check("p4_addr_next", obs_addr, 32'h0000_2000);
        wait_valid("p4_first", 32'h0000_2000);

        // slow memory: gnt after 2 waiting cycles, 3-cycle response
        gd_lo = 2; gd_hi = 2; lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 6; i++) step();
        d0 = deliveries; last_b = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!last_b) check("p5_bubble_between", obs_bub, 1);
            last_b = obs_bub;
        end
        check("p5_progress", deliveries - d0 >= 4, 1);

        // randomized traffic
        gd_lo = 0; gd_hi = 2; lat_lo = 1; lat_hi = 3;
        d0 = deliveries;
        for (int i = 0; i < 300; i++) begin
            stall_in = ($urandom_range(3, 0) == 0);
            redir_in = ($urandom_range(19, 0) == 0);
            tgt_in   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15, 0) : $urandom;
            step();
        end
        stall_in = 0; redir_in = 0;
        check("p6_progress", deliveries - d0 >= 20, 1);

        // asynchronous reset in the middle of traffic
        #3 nrst = 0;
        #1;
        check("mrst_bubble", bubble_f, 1);
        check("mrst_req", imem_a.imem_req, 0);
        check("mrst_pcf", pcf, 0);
        step();
        nrst = 1; gd_lo = 0; gd_hi = 0; lat_lo = 1; lat_hi = 1; gnt_dly = 0;
        step();
        check("mrst_first_req", obs_req, 1);
        check("mrst_first_addr", obs_addr, 0);

        // address wrap from RESET_PC = FFFF_FFF8
        nrst_b = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 3) begin
                check("wrap_req", obs_b_req, 1);
                check("wrap_addr", obs_b_addr, wrap_addr[i]);
            end
            hit = (i >= 2);
            if (hit) begin
                check("wrap_valid", obs_b_bub, 0);
                check("wrap_pcf", obs_b_pcf, wrap_addr[i-2]);
                check("wrap_pc4", obs_b_pc4, wrap_addr[i-2] + 32'd4);
                check("wrap_inst", obs_b_inst, memf(wrap_addr[i-2]));
            end
        end
        check("wrap_pc4_at_top", (obs_b_pcf == 32'h0) ? 32'h0 : obs_b_pc4, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
